// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses over a byte-addressed memory port, read-modify-write for sub-word stores.
// Latency from req sample: load +2, word store +2, byte/half store +3, illegal/trapped access +1 (done pulse).
// Backpressure: none queued; req is sampled only in IDLE and ignored while busy.
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag misaligned H/HU/W accesses with err instead of accessing memory.
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_err,
  output logic        o_busy,
  output logic [31:0] o_mem_A,
  output logic [31:0] o_mem_WD,
  output logic        o_mem_WE,
  input  logic [31:0] i_mem_RD
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_err;
  logic        r_busy;
  logic [31:0] r_mem_a;
  logic        r_mem_we;

  logic        w_illegal;
  logic        w_misalign;
  logic [31:0] w_load_ext;
  logic [31:0] w_merge;

  // Only the five RISC-V load/store size codes are legal
  always_comb begin
    w_illegal = 1'b0;
    case (i_funct3)
      3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
      default:                w_illegal = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfwords need an even address, words a 4-byte aligned address
  always_comb begin
    w_misalign = 1'b0;
    if (i_funct3[1:0] == 2'b01)
      w_misalign = i_addr[0];
    else if (i_funct3[1:0] == 2'b10)
      w_misalign = (i_addr[1:0] != 2'b00);
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Extend the read word straight from the memory port so rdata is valid in the DONE cycle
  always_comb begin
    w_load_ext = i_mem_RD;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{i_mem_RD[31]}}, i_mem_RD[31:24]};
      3'b100:  w_load_ext = {24'h000000, i_mem_RD[31:24]};
      3'b001:  w_load_ext = {{16{i_mem_RD[31]}}, i_mem_RD[31:16]};
      3'b101:  w_load_ext = {16'h0000, i_mem_RD[31:16]};
      default: w_load_ext = i_mem_RD;
    endcase
  end

  // Sub-word stores replace the leading byte/half of the word captured in READ
  always_comb begin
    w_merge = r_wdata;
    case (r_funct3[1:0])
      2'b00:   w_merge = {r_wdata[7:0], r_word[23:0]};
      2'b01:   w_merge = {r_wdata[15:0], r_word[15:0]};
      default: w_merge = r_wdata;
    endcase
  end

  // Access FSM with registered status and memory-address outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_addr   <= 32'h0;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_wdata  <= 32'h0;
      r_word   <= 32'h0;
      r_rdata  <= 32'h0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_mem_a  <= 32'h0;
      r_mem_we <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done   <= 1'b0;
          r_err    <= 1'b0;
          r_mem_we <= 1'b0;
          r_mem_a  <= 32'h0;
          if (i_req) begin
            r_addr   <= i_addr;
            r_we     <= i_we;
            r_funct3 <= i_funct3;
            r_wdata  <= i_wdata;
            r_busy   <= 1'b1;
            if (w_illegal || w_misalign) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (i_we && (i_funct3[1:0] == 2'b10)) begin
              r_state  <= WRITE;
              r_mem_a  <= i_addr;
              r_mem_we <= 1'b1;
            end else begin
              r_state <= READ;
              r_mem_a <= i_addr;
            end
          end
        end
        READ: begin
          r_word <= i_mem_RD;
          if (r_we) begin
            r_state  <= WRITE;
            r_mem_we <= 1'b1;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_rdata <= w_load_ext;
            r_mem_a <= 32'h0;
          end
        end
        WRITE: begin
          r_state  <= DONE;
          r_done   <= 1'b1;
          r_mem_we <= 1'b0;
          r_mem_a  <= 32'h0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rdata  = r_rdata;
  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_busy   = r_busy;
  assign o_mem_A  = r_mem_a;
  // Write data only presented while the write strobe is registered high
  assign o_mem_WD = (r_state == WRITE) ? w_merge : 32'h0;
  // Reset kills an in-flight write immediately, not one edge later
  assign o_mem_WE = r_mem_we & ~i_reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-addressed memory model.
// Table of directed accesses plus hand sequences for req-while-busy and reset during WRITE.
// Memory model reads combinationally and writes four bytes on a rising edge with mem_WE.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  logic [7:0] mem [0:511];

  int checks;
  int failures;

  load_store_unit dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_req    (req),
    .i_we     (we),
    .i_funct3 (funct3),
    .i_addr   (addr),
    .i_wdata  (wdata),
    .o_rdata  (rdata),
    .o_done   (done),
    .o_err    (err),
    .o_busy   (busy),
    .o_mem_A  (mem_A),
    .o_mem_WD (mem_WD),
    .o_mem_WE (mem_WE),
    .i_mem_RD (mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] a0, a1, a2, a3;
  assign a0 = mem_A[8:0];
  assign a1 = mem_A[8:0] + 9'd1;
  assign a2 = mem_A[8:0] + 9'd2;
  assign a3 = mem_A[8:0] + 9'd3;
  assign mem_RD = {mem[a0], mem[a1], mem[a2], mem[a3]};

  always @(posedge clk) begin
    if (mem_WE) begin
      mem[a0] <= mem_WD[31:24];
      mem[a1] <= mem_WD[23:16];
      mem[a2] <= mem_WD[15:8];
      mem[a3] <= mem_WD[7:0];
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wecyc;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    int wecnt;
    int wecyc;
    logic busy1;
    @(negedge clk);
    req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    req = 1'b0;
    cyc = 1; wecnt = 0; wecyc = 0;
    busy1 = busy;
    while (!done && cyc < 8) begin
      if (mem_WE) begin wecnt++; wecyc = cyc; end
      @(posedge clk); #1;
      cyc++;
    end
    if (mem_WE) wecnt++;
    chk($sformatf("v%0d latency", idx), cyc, v.lat);
    chk($sformatf("v%0d err", idx), {31'h0, err}, {31'h0, v.err});
    chk($sformatf("v%0d rdata", idx), rdata, v.rdata);
    chk($sformatf("v%0d we_pulses", idx), wecnt, (v.wecyc != 0) ? 1 : 0);
    chk($sformatf("v%0d we_cycle", idx), wecyc, v.wecyc);
    chk($sformatf("v%0d busy", idx), {31'h0, busy1}, 32'h1);
    @(posedge clk); #1;
    chk($sformatf("v%0d done_pulse", idx), {31'h0, done}, 32'h0);
    chk($sformatf("v%0d idle_memA", idx), mem_A, 32'h0);
  endtask

  initial begin
    int wecnt;
    int dcnt;
    checks = 0; failures = 0;
    req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h190] = 8'h11; mem[9'h191] = 8'h22; mem[9'h192] = 8'h33; mem[9'h193] = 8'h44;
    mem[9'h194] = 8'h80;

    //          we    f3      addr         wdata         rdata         err  lat wecyc
    vt[0]  = '{1'b0, 3'b000, 32'h190, 32'h0,         32'h00000011, 1'b0, 2, 0};
    vt[1]  = '{1'b0, 3'b000, 32'h194, 32'h0,         32'hFFFFFF80, 1'b0, 2, 0};
    vt[2]  = '{1'b0, 3'b100, 32'h194, 32'h0,         32'h00000080, 1'b0, 2, 0};
    vt[3]  = '{1'b0, 3'b001, 32'h192, 32'h0,         32'h00003344, 1'b0, 2, 0};
    vt[4]  = '{1'b0, 3'b001, 32'h194, 32'h0,         32'hFFFF8000, 1'b0, 2, 0};
    vt[5]  = '{1'b0, 3'b101, 32'h194, 32'h0,         32'h00008000, 1'b0, 2, 0};
`ifdef LSU_MISALIGN_TRAP_EN
    vt[6]  = '{1'b0, 3'b010, 32'h191, 32'h0,         32'h00008000, 1'b1, 1, 0};
    vt[7]  = '{1'b1, 3'b000, 32'h191, 32'h000000AB,  32'h00008000, 1'b0, 3, 2};
`else
    vt[6]  = '{1'b0, 3'b010, 32'h191, 32'h0,         32'h22334480, 1'b0, 2, 0};
    vt[7]  = '{1'b1, 3'b000, 32'h191, 32'h000000AB,  32'h22334480, 1'b0, 3, 2};
`endif
    vt[8]  = '{1'b0, 3'b010, 32'h190, 32'h0,         32'h11AB3344, 1'b0, 2, 0};
    vt[9]  = '{1'b1, 3'b010, 32'h198, 32'hDEADBEEF,  32'h11AB3344, 1'b0, 2, 1};
    vt[10] = '{1'b0, 3'b010, 32'h198, 32'h0,         32'hDEADBEEF, 1'b0, 2, 0};
    vt[11] = '{1'b1, 3'b001, 32'h19A, 32'hFFFF1234,  32'hDEADBEEF, 1'b0, 3, 2};
    vt[12] = '{1'b0, 3'b010, 32'h198, 32'h0,         32'hDEAD1234, 1'b0, 2, 0};
    vt[13] = '{1'b0, 3'b011, 32'h190, 32'h0,         32'hDEAD1234, 1'b1, 1, 0};
    vt[14] = '{1'b1, 3'b111, 32'h190, 32'hFFFFFFFF,  32'hDEAD1234, 1'b1, 1, 0};
    vt[15] = '{1'b0, 3'b100, 32'h190, 32'h0,         32'h00000011, 1'b0, 2, 0};

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done",  {31'h0, done},   32'h0);
    chk("rst_err",   {31'h0, err},    32'h0);
    chk("rst_busy",  {31'h0, busy},   32'h0);
    chk("rst_memWE", {31'h0, mem_WE}, 32'h0);
    chk("rst_rdata", rdata,  32'h0);
    chk("rst_memA",  mem_A,  32'h0);
    chk("rst_memWD", mem_WD, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(i, vt[i]);

    // Memory contents after the sub-word and word stores
    chk("mem191", {24'h0, mem[9'h191]}, 32'hAB);
    chk("mem192", {24'h0, mem[9'h192]}, 32'h33);
    chk("mem193", {24'h0, mem[9'h193]}, 32'h44);
    chk("mem194", {24'h0, mem[9'h194]}, 32'h80);
    chk("mem19C", {24'h0, mem[9'h19C]}, 32'h00);
    chk("mem190_no_illegal_write", {24'h0, mem[9'h190]}, 32'h11);

    // req held during a load with store fields must be ignored
    wecnt = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h198; wdata = 32'h0;
    @(posedge clk); #1;
    we = 1'b1;
    if (mem_WE) wecnt++;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    if (mem_WE) wecnt++;
    chk("busyreq_done",  {31'h0, done}, 32'h1);
    chk("busyreq_rdata", rdata, 32'hDEAD1234);
    repeat (3) begin
      @(posedge clk); #1;
      if (mem_WE) wecnt++;
    end
    chk("busyreq_no_write", wecnt, 0);
    chk("busyreq_idle", {31'h0, busy}, 32'h0);
    chk("busyreq_mem198", {24'h0, mem[9'h198]}, 32'hDE);

    // Reset asserted during the WRITE cycle of a halfword store
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'h190; wdata = 32'h00005555;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("rstwr_we_before", {31'h0, mem_WE}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstwr_we_gated", {31'h0, mem_WE}, 32'h0);
    @(posedge clk); #1;
    chk("rstwr_busy", {31'h0, busy}, 32'h0);
    chk("rstwr_done", {31'h0, done}, 32'h0);
    chk("rstwr_rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("rstwr_no_done", dcnt, 0);
    chk("rstwr_mem190", {24'h0, mem[9'h190]}, 32'h11);
    chk("rstwr_mem191", {24'h0, mem[9'h191]}, 32'hAB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
